// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t       : two-state controller encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH : default parallel word width in bits
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bitcnt.sv
// Bit counter for the serializer: tracks which bit of the current word is
// on the serial output.
//   clk : clock, rising-edge active
//   rst : asynchronous active-low reset, clears the count
//   clr : synchronous clear to 0 (takes priority over inc)
//   inc : synchronous increment by one
//   tc  : terminal count, high when the count equals WIDTH-1
module piso_bitcnt
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  // Counter register: clear wins so a fresh word always starts at bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready input handshake.
// A word is accepted when in_valid and in_ready are both high on a rising
// edge; its first bit appears on ser_out the following cycle. Words can be
// streamed back to back without a bubble by holding in_valid high.
//   clk       : clock, rising-edge active
//   rst       : asynchronous active-low reset
//   in_data   : parallel word to serialize (sampled only at acceptance)
//   in_valid  : in_data holds a word to transfer
//   in_ready  : a word can be accepted this cycle
//   ser_out   : serial bit stream (0 while idle)
//   ser_valid : ser_out carries a payload bit
//   ser_last  : ser_out carries the final bit of a word
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             tc;
  logic             in_shift;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;

  assign in_shift = (state == SHIFT);
  assign in_ready = !in_shift || tc;
  assign accept   = in_valid && in_ready;

  // The count restarts at 0 both when a new word is loaded and when the
  // block drops back to idle, so it is always 0 on entry to SHIFT.
  assign cnt_clr = !in_shift || tc;
  assign cnt_inc = in_shift && !tc;

  piso_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (tc)
  );

  // Controller: the default arm recovers from any unexpected encoding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= accept ? SHIFT : IDLE;
        SHIFT:   state <= (tc && !in_valid) ? IDLE : SHIFT;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register: the bit on ser_out is always held at the end selected
  // by MSB_FIRST, so shifting toward that end presents the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= in_data;
    end else if (in_shift && !tc) begin
      if (MSB_FIRST != 0) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end else if (in_shift) begin
      sreg <= '0;
    end
  end

  assign ser_out   = in_shift && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
  assign ser_valid = in_shift;
  assign ser_last  = in_shift && tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. Two instances share the same
// inputs: one MSB-first, one LSB-first. A queue-based reference model holds
// the bits each instance still owes; table vectors, hand sequences and a
// random phase are all checked against it.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;

  logic ready_m, out_m, valid_m, last_m;
  logic ready_l, out_l, valid_l, last_l;

  int tests;
  int failures;

  // Bits still to appear on ser_out, front = bit currently presented.
  bit q_m[$];
  bit q_l[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[7];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ready_m),
    .ser_out   (out_m),
    .ser_valid (valid_m),
    .ser_last  (last_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ready_l),
    .ser_out   (out_l),
    .ser_valid (valid_l),
    .ser_last  (last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances with what the model predicts.
  task automatic checkOutput();
    cmp("valid_m", 16'(valid_m), 16'(q_m.size() > 0));
    cmp("out_m",   16'(out_m),   16'((q_m.size() > 0) ? q_m[0] : 1'b0));
    cmp("last_m",  16'(last_m),  16'(q_m.size() == 1));
    cmp("ready_m", 16'(ready_m), 16'(q_m.size() <= 1));
    cmp("valid_l", 16'(valid_l), 16'(q_l.size() > 0));
    cmp("out_l",   16'(out_l),   16'((q_l.size() > 0) ? q_l[0] : 1'b0));
    cmp("last_l",  16'(last_l),  16'(q_l.size() == 1));
    cmp("ready_l", 16'(ready_l), 16'(q_l.size() <= 1));
  endtask

  // Model of one rising edge: the presented bit is consumed, and a word is
  // taken when valid meets ready (ready = at most the last bit remains).
  task automatic modelEdge();
    bit rdy;
    rdy = (q_m.size() <= 1);
    if (q_m.size() > 0) void'(q_m.pop_front());
    if (q_l.size() > 0) void'(q_l.pop_front());
    if (in_valid && rdy) begin
      for (int i = 0; i < 8; i++) begin
        q_m.push_back(in_data[7-i]);
        q_l.push_back(in_data[i]);
      end
    end
  endtask

  task automatic tick();
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    in_valid = valid;
    in_data  = data;
    tick();
  endtask

  initial begin
    logic [7:0]  got_m, got_l;
    logic [15:0] trace16, ready16;
    int          low_count;

    tests    = 0;
    failures = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    vecs[0] = '{8'hD0, 8'b11010000, 8'b00001011};
    vecs[1] = '{8'h0B, 8'b00001011, 8'b11010000};
    vecs[2] = '{8'hA5, 8'b10100101, 8'b10100101};
    vecs[3] = '{8'h3C, 8'b00111100, 8'b00111100};
    vecs[4] = '{8'h96, 8'b10010110, 8'b01101001};
    vecs[5] = '{8'hFF, 8'b11111111, 8'b11111111};
    vecs[6] = '{8'h01, 8'b00000001, 8'b10000000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    modelEdge();
    #1;

    // Table: one word at a time, in_data scrambled while shifting.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, vecs[v].data);
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        in_data = 8'($urandom);
        got_m[7-k] = out_m;
        got_l[7-k] = out_l;
        tick();
      end
      cmp("tbl_stream_m", 16'(got_m), 16'(vecs[v].exp_msb));
      cmp("tbl_stream_l", 16'(got_l), 16'(vecs[v].exp_lsb));
      cmp("tbl_idle_after", 16'(valid_m), 16'h0);
      tick();
    end

    // Back-to-back words A5 then 3C with in_valid held high.
    applyStimulus(1'b1, 8'hA5);
    in_data = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      trace16[15-k] = out_m;
      ready16[15-k] = ready_m;
      if (!valid_m) trace16[15-k] = 1'bx;
      tick();
      if (k == 7) in_valid = 1'b0;
    end
    cmp("b2b_stream", trace16, 16'hA53C);
    cmp("b2b_ready",  ready16, 16'h0101);
    tick();

    // Reset asserted mid-word (bit 3 of FF) then first edge accepts 5A.
    applyStimulus(1'b1, 8'hFF);
    in_valid = 1'b0;
    repeat (3) tick();
    cmp("pre_rst_valid", 16'(valid_m), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    q_m.delete();
    q_l.delete();
    cmp("rst_out",   16'({out_m, out_l}),     16'h0);
    cmp("rst_valid", 16'({valid_m, valid_l}), 16'h0);
    cmp("rst_last",  16'({last_m, last_l}),   16'h0);
    cmp("rst_ready", 16'({ready_m, ready_l}), 16'h3);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #4;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got_m[7-k] = out_m;
      tick();
    end
    cmp("post_rst_word", 16'(got_m), 16'h5A);
    tick();

    // Three idle cycles between C3 and 81.
    applyStimulus(1'b1, 8'hC3);
    in_valid = 1'b0;
    repeat (8) tick();
    low_count = 0;
    for (int g = 0; g < 3; g++) begin
      if (!valid_m) low_count++;
      if (g == 2) begin
        in_valid = 1'b1;
        in_data  = 8'h81;
      end
      tick();
    end
    in_valid = 1'b0;
    cmp("gap_low_cycles", 16'(low_count), 16'd3);
    cmp("gap_first_bit",  16'({valid_m, out_m}), 16'h3);
    repeat (9) tick();

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom));
    end
    in_valid = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
